// File: rtl/register_file_if.sv
// register_file_if: write port and two read ports of the register file
interface register_file_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
);
  logic              Write_En;
  logic [ADDR_W-1:0] Write_Addr;
  logic [WIDTH-1:0]  Write_Data;
  logic [ADDR_W-1:0] Read_Addr_A;
  logic [WIDTH-1:0]  Read_Data_A;
  logic [ADDR_W-1:0] Read_Addr_B;
  logic [WIDTH-1:0]  Read_Data_B;
  modport master (
    output Write_En, Write_Addr, Write_Data, Read_Addr_A, Read_Addr_B,
    input  Read_Data_A, Read_Data_B
  );
  modport slave (
    input  Write_En, Write_Addr, Write_Data, Read_Addr_A, Read_Addr_B,
    output Read_Data_A, Read_Data_B
  );
endinterface

// File: rtl/register_file.sv
// register_file: DEPTH x WIDTH array, one sync write port, two combinational read ports
module register_file #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = 5,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input logic Clock,
  input logic Reset_n,
  register_file_if.slave bus
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic             wr_ok;
  logic             zero_a;
  logic             zero_b;
  // a write takes effect only outside reset and never targets a hardwired x0
  always_comb begin
    wr_ok  = bus.Write_En && !Reset_n && !(ZERO_REG && bus.Write_Addr == '0);
    zero_a = ZERO_REG && bus.Read_Addr_A == '0;
    zero_b = ZERO_REG && bus.Read_Addr_B == '0;
  end
  // reset clears every entry and wins over a simultaneous write
  always_ff @(posedge Clock) begin
    if (Reset_n)
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    else if (wr_ok)
      mem[bus.Write_Addr] <= bus.Write_Data;
  end
  // reads forward the in-flight write when bypass is enabled, else show stored state
  always_comb begin
    bus.Read_Data_A = zero_a ? '0 :
                      (BYPASS && wr_ok && bus.Write_Addr == bus.Read_Addr_A) ? bus.Write_Data :
                      mem[bus.Read_Addr_A];
    bus.Read_Data_B = zero_b ? '0 :
                      (BYPASS && wr_ok && bus.Write_Addr == bus.Read_Addr_B) ? bus.Write_Data :
                      mem[bus.Read_Addr_B];
  end
endmodule

// File: tb/tb_register_file.sv
// tb_register_file: table, directed and randomized checks of register_file variants
module tb_register_file;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  register_file_if #(.WIDTH(32), .ADDR_W(5)) b0 ();
  register_file_if #(.WIDTH(32), .ADDR_W(5)) b1 ();
  register_file_if #(.WIDTH(8),  .ADDR_W(2)) b2 ();

  register_file u0 (.Clock(clk), .Reset_n(rst), .bus(b0));
  register_file #(.ZERO_REG(1'b0), .BYPASS(1'b0)) u1 (.Clock(clk), .Reset_n(rst), .bus(b1));
  register_file #(.WIDTH(8), .DEPTH(4), .ADDR_W(2)) u2 (.Clock(clk), .Reset_n(rst), .bus(b2));

  int checks = 0;
  int errors = 0;
  logic [31:0] m0 [32];
  logic [31:0] m1 [32];
  logic [7:0]  m2 [4];

  typedef struct {
    logic        rst;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [31:0] ea;
    logic [31:0] eb;
  } vec_t;
  vec_t tbl [13];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) begin m0[i] = '0; m1[i] = '0; end
      for (int i = 0; i < 4; i++) m2[i] = '0;
    end else begin
      if (b0.Write_En && b0.Write_Addr != 0) m0[b0.Write_Addr] = b0.Write_Data;
      if (b1.Write_En) m1[b1.Write_Addr] = b1.Write_Data;
      if (b2.Write_En && b2.Write_Addr != 0) m2[b2.Write_Addr] = b2.Write_Data;
    end
    @(negedge clk);
  endtask

  function automatic logic [31:0] e0(input logic [4:0] a);
    if (a == 0) return '0;
    if (!rst && b0.Write_En && b0.Write_Addr == a) return b0.Write_Data;
    return m0[a];
  endfunction

  initial begin
    tbl[0]  = '{1'b1, 1'b1, 5'd3, 32'h55,       5'd3, 5'd0, 32'h0,        32'h0};
    tbl[1]  = '{1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd3, 32'hDEADBEEF, 32'h0};
    tbl[2]  = '{1'b0, 1'b0, 5'd0, 32'h0,        5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF};
    tbl[3]  = '{1'b0, 1'b0, 5'd0, 32'h0,        5'd6, 5'd0, 32'h0,        32'h0};
    tbl[4]  = '{1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 32'h0,        32'h0};
    tbl[5]  = '{1'b0, 1'b0, 5'd0, 32'h0,        5'd0, 5'd5, 32'h0,        32'hDEADBEEF};
    tbl[6]  = '{1'b0, 1'b1, 5'd7, 32'h11,       5'd7, 5'd7, 32'h11,       32'h11};
    tbl[7]  = '{1'b0, 1'b1, 5'd7, 32'h22,       5'd7, 5'd5, 32'h22,       32'hDEADBEEF};
    tbl[8]  = '{1'b0, 1'b0, 5'd0, 32'h0,        5'd7, 5'd7, 32'h22,       32'h22};
    tbl[9]  = '{1'b1, 1'b0, 5'd0, 32'h0,        5'd7, 5'd5, 32'h22,       32'hDEADBEEF};
    tbl[10] = '{1'b0, 1'b0, 5'd0, 32'h0,        5'd7, 5'd5, 32'h0,        32'h0};
    tbl[11] = '{1'b0, 1'b1, 5'd9, 32'h99,       5'd9, 5'd1, 32'h99,       32'h0};
    tbl[12] = '{1'b0, 1'b0, 5'd0, 32'h0,        5'd9, 5'd9, 32'h99,       32'h99};

    {b0.Write_En, b0.Write_Addr, b0.Write_Data, b0.Read_Addr_A, b0.Read_Addr_B} = '0;
    {b1.Write_En, b1.Write_Addr, b1.Write_Data, b1.Read_Addr_A, b1.Read_Addr_B} = '0;
    {b2.Write_En, b2.Write_Addr, b2.Write_Data, b2.Read_Addr_A, b2.Read_Addr_B} = '0;
    @(negedge clk);
    rst = 1'b1;
    tick();
    rst = 1'b0;

    for (int i = 1; i < 32; i++) begin
      b0.Write_En = 1'b1; b0.Write_Addr = 5'(i); b0.Write_Data = 32'(i);
      tick();
    end
    b0.Write_En = 1'b0;
    rst = 1'b1;
    b0.Read_Addr_A = 5'd17; b0.Read_Addr_B = 5'd31;
    #1;
    check("during_reset A", b0.Read_Data_A, 32'd17);
    check("during_reset B", b0.Read_Data_B, 32'd31);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      b0.Read_Addr_A = 5'(i); b0.Read_Addr_B = 5'(31 - i);
      #1;
      check($sformatf("clear A%0d", i), b0.Read_Data_A, 32'h0);
      check($sformatf("clear B%0d", 31 - i), b0.Read_Data_B, 32'h0);
    end

    for (int i = 0; i < 13; i++) begin
      rst = tbl[i].rst;
      b0.Write_En = tbl[i].we; b0.Write_Addr = tbl[i].wa; b0.Write_Data = tbl[i].wd;
      b0.Read_Addr_A = tbl[i].ra; b0.Read_Addr_B = tbl[i].rb;
      #1;
      check($sformatf("tbl%0d A", i), b0.Read_Data_A, tbl[i].ea);
      check($sformatf("tbl%0d B", i), b0.Read_Data_B, tbl[i].eb);
      tick();
    end
    b0.Write_En = 1'b0;
    rst = 1'b0;

    b1.Write_En = 1'b1; b1.Write_Addr = 5'd0; b1.Write_Data = 32'hFFFFFFFF;
    b1.Read_Addr_A = 5'd0; b1.Read_Addr_B = 5'd0;
    #1;
    check("nz x0 before", b1.Read_Data_A, 32'h0);
    tick();
    b1.Write_En = 1'b0;
    #1;
    check("nz x0 after", b1.Read_Data_B, 32'hFFFFFFFF);
    b1.Write_En = 1'b1; b1.Write_Addr = 5'd7; b1.Write_Data = 32'h11;
    tick();
    b1.Write_Data = 32'h22; b1.Read_Addr_A = 5'd7; b1.Read_Addr_B = 5'd7;
    #1;
    check("nobyp before", b1.Read_Data_A, 32'h11);
    tick();
    b1.Write_En = 1'b0;
    #1;
    check("nobyp after", b1.Read_Data_A, 32'h22);

    for (int i = 0; i < 4; i++) begin
      b2.Write_En = 1'b1; b2.Write_Addr = 2'(i); b2.Write_Data = 8'hA0 + 8'(i);
      tick();
    end
    b2.Write_En = 1'b0;
    for (int i = 0; i < 4; i++) begin
      b2.Read_Addr_A = 2'(i); b2.Read_Addr_B = 2'(3 - i);
      #1;
      check($sformatf("small A%0d", i), 32'(b2.Read_Data_A), i == 0 ? 32'h0 : 32'hA0 + 32'(i));
      check($sformatf("small B%0d", 3 - i), 32'(b2.Read_Data_B), i == 3 ? 32'h0 : 32'hA3 - 32'(i));
    end

    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 15) == 0);
      b0.Write_En = 1'($urandom_range(0, 1)); b0.Write_Addr = 5'($urandom); b0.Write_Data = $urandom;
      b0.Read_Addr_A = ($urandom_range(0, 2) == 0) ? b0.Write_Addr : 5'($urandom);
      b0.Read_Addr_B = ($urandom_range(0, 2) == 0) ? b0.Write_Addr : 5'($urandom);
      b1.Write_En = 1'($urandom_range(0, 1)); b1.Write_Addr = 5'($urandom); b1.Write_Data = $urandom;
      b1.Read_Addr_A = ($urandom_range(0, 2) == 0) ? b1.Write_Addr : 5'($urandom);
      b1.Read_Addr_B = 5'($urandom);
      #1;
      check($sformatf("rnd%0d u0 A", n), b0.Read_Data_A, e0(b0.Read_Addr_A));
      check($sformatf("rnd%0d u0 B", n), b0.Read_Data_B, e0(b0.Read_Addr_B));
      check($sformatf("rnd%0d u1 A", n), b1.Read_Data_A, m1[b1.Read_Addr_A]);
      check($sformatf("rnd%0d u1 B", n), b1.Read_Data_B, m1[b1.Read_Addr_B]);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
